// File: rtl/uart_pkg.sv
// Shared definitions for the UART-side blocks: feeder FSM encoding, default
// buffer depth and the log2 helper used to size pointers.
package uart_pkg;

    localparam int unsigned FEEDER_DEPTH = 16;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ASSERT    = 2'd1,
        ST_WAIT_DONE = 2'd2
    } feeder_state_t;

    // Ceiling log2; DEPTH is expected to be a power of two >= 2.
    function automatic int unsigned log2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered storage and registered full/empty/count.
// Rejected pushes (full) and pops (empty) are silently ignored.
module sync_fifo
    import uart_pkg::*;
#(
    parameter  int unsigned WIDTH  = 8,
    parameter  int unsigned DEPTH  = FEEDER_DEPTH,
    localparam int unsigned ADDR_W = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  wr_data,
    output logic [WIDTH-1:0]  head_c,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count
);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok_c;
    logic              pop_ok_c;
    logic [ADDR_W:0]   count_next_c;

    assign push_ok_c = push && !full;
    assign pop_ok_c  = pop && !empty;
    assign head_c    = mem[rd_ptr];

    always_comb begin
        count_next_c = count;
        if (push_ok_c && !pop_ok_c) begin
            count_next_c = count + (ADDR_W+1)'(1);
        end else if (pop_ok_c && !push_ok_c) begin
            count_next_c = count - (ADDR_W+1)'(1);
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            full   <= 1'b0;
        end else begin
            if (push_ok_c) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok_c) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count <= count_next_c;
            empty <= (count_next_c == '0);
            full  <= (count_next_c == (ADDR_W+1)'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffered byte source for the UART transmitter: queues fabric bytes and
// hands them to the UART one transmit pulse at a time.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int unsigned DEPTH  = FEEDER_DEPTH,
    localparam int unsigned ADDR_W = log2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [7:0]        wr_data,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              transmit,
    output logic [7:0]        tx_byte,
    input  logic              is_transmitting
);

    feeder_state_t state;
    logic          pop_c;
    logic [7:0]    head_c;

    assign pop_c = (state == ST_IDLE) && !empty && !is_transmitting;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (wr_en),
        .pop     (pop_c),
        .wr_data (wr_data),
        .head_c  (head_c),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // transmit drops as soon as the UART is busy so its recover stage exits at once.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_IDLE;
            transmit <= 1'b0;
            tx_byte  <= 8'h00;
            overflow <= 1'b0;
        end else begin
            if (wr_en && full) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (pop_c) begin
                        tx_byte  <= head_c;
                        transmit <= 1'b1;
                        state    <= ST_ASSERT;
                    end
                end
                ST_ASSERT: begin
                    if (is_transmitting) begin
                        transmit <= 1'b0;
                        state    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!is_transmitting) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    transmit <= 1'b0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder with a behavioural UART and a queue-based byte model.
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       full, empty, overflow, transmit;
    logic [4:0] count;
    logic [7:0] tx_byte;
    logic       uart_busy;

    uart_tx_feeder #(.DEPTH(DEPTH)) dut (
        .clk             (clk),
        .rst             (rst),
        .wr_en           (wr_en),
        .wr_data         (wr_data),
        .full            (full),
        .empty           (empty),
        .count           (count),
        .overflow        (overflow),
        .transmit        (transmit),
        .tx_byte         (tx_byte),
        .is_transmitting (uart_busy)
    );

    always #5 clk = ~clk;

    // Behavioural UART: samples transmit when idle, busy for busy_len cycles.
    logic       model_busy = 1'b0;
    logic       hold = 1'b0;
    logic       hold_q = 1'b0;
    int         busy_cnt = 0;
    int         busy_len = 20;
    logic [7:0] last_cap = 8'h00;
    logic [7:0] sent_q[$];
    logic [7:0] exp_q[$];
    int         pulse_q[$];
    int         run = 0;
    int         stab_err = 0;
    int         order_err = 0;
    logic       prev_tx = 1'b0;
    int         n_chk = 0;
    int         n_pass = 0;
    int         n_fail = 0;

    assign uart_busy = model_busy | hold_q;

    always @(posedge clk) begin
        if (rst) begin
            model_busy <= 1'b0;
            busy_cnt   <= 0;
            hold_q     <= 1'b0;
        end else begin
            hold_q <= hold;
            if (busy_cnt > 0) begin
                busy_cnt <= busy_cnt - 1;
                if (busy_cnt == 1) model_busy <= 1'b0;
            end else if (transmit && !uart_busy) begin
                sent_q.push_back(tx_byte);
                last_cap   <= tx_byte;
                model_busy <= 1'b1;
                busy_cnt   <= busy_len;
            end
        end
    end

    always @(posedge clk) begin
        if (transmit) begin
            run = run + 1;
        end else if (run > 0) begin
            pulse_q.push_back(run);
            run = 0;
        end
    end

    always @(negedge clk) begin
        if (model_busy && tx_byte !== last_cap) stab_err++;
        if (transmit && !prev_tx && uart_busy) order_err++;
        prev_tx = transmit;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] d, input bit accepted);
        wr_en   = 1'b1;
        wr_data = d;
        if (accepted) exp_q.push_back(d);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (!(sent_q.size() >= exp_q.size() && !uart_busy && empty && !transmit) && t < 4000) begin
            @(negedge clk);
            t++;
        end
        check({tag, "_drain_in_time"}, 32'(t < 4000), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_stream(input string tag);
        int bad;
        check({tag, "_nbytes"}, 32'(sent_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < sent_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(sent_q[i]), 32'(exp_q[i]));
        end
        bad = 0;
        foreach (pulse_q[i]) if (pulse_q[i] != 2) bad++;
        check({tag, "_pulse_width"}, 32'(bad), 32'd0);
        check({tag, "_npulses"}, 32'(pulse_q.size()), 32'(sent_q.size()));
        sent_q.delete();
        exp_q.delete();
        pulse_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_transmit", 32'(transmit), 32'd0);
        check("rst_tx_byte", 32'(tx_byte), 32'h00);
        check("rst_count", 32'(count), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single byte: push latency and a 2-cycle pulse.
        push(8'hA5, 1'b1);
        check("single_count1", 32'(count), 32'd1);
        check("single_tx_not_yet", 32'(transmit), 32'd0);
        @(negedge clk);
        check("single_tx_high", 32'(transmit), 32'd1);
        check("single_tx_byte", 32'(tx_byte), 32'hA5);
        drain("single");
        check("single_count0", 32'(count), 32'd0);
        check("single_empty", 32'(empty), 32'd1);
        check_stream("single");

        // Ordering of a consecutive burst.
        for (int i = 1; i <= 5; i++) push(8'(i), 1'b1);
        drain("order");
        check_stream("order");

        // Full / overflow, with the rejected push landing on a pop cycle.
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < DEPTH; i++) push(8'h40 + 8'(i), 1'b1);
        check("full_flag", 32'(full), 32'd1);
        check("full_count", 32'(count), 32'd16);
        check("full_no_ovf_yet", 32'(overflow), 32'd0);
        hold = 1'b0;
        @(negedge clk);
        push(8'h50, 1'b0);
        check("ovf_count_after_pop", 32'(count), 32'd15);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_full_clear", 32'(full), 32'd0);
        drain("full");
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("full_drained_count", 32'(count), 32'd0);
        check_stream("full");

        // Wrap-around: 40 bytes in bursts of 10.
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 10; i++) push(8'(b * 10 + i), 1'b1);
            drain("wrap");
        end
        check_stream("wrap");

        // Simultaneous push and pop at count 3.
        hold = 1'b1;
        repeat (2) @(negedge clk);
        push(8'h61, 1'b1);
        push(8'h62, 1'b1);
        push(8'h63, 1'b1);
        check("simul_count_before", 32'(count), 32'd3);
        hold = 1'b0;
        @(negedge clk);
        push(8'h7E, 1'b1);
        check("simul_count_kept", 32'(count), 32'd3);
        check("simul_transmit", 32'(transmit), 32'd1);
        drain("simul");
        check_stream("simul");

        // Random traffic with a random UART busy time, never exceeding capacity.
        for (int c = 0; c < 600; c++) begin
            busy_len = int'($urandom_range(3, 25));
            if (($urandom % 3) == 0 && (exp_q.size() - sent_q.size()) < DEPTH - 1)
                push(8'($urandom), 1'b1);
            else
                @(negedge clk);
        end
        busy_len = 20;
        drain("rand");
        check("rand_ovf_still_sticky", 32'(overflow), 32'd1);
        check_stream("rand");

        // Reset while in ASSERT with 4 bytes still queued.
        hold = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 5; i++) push(8'h91 + 8'(i), 1'b0);
        hold = 1'b0;
        repeat (2) @(negedge clk);
        check("rstmid_in_assert", 32'(transmit), 32'd1);
        check("rstmid_count4", 32'(count), 32'd4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_transmit", 32'(transmit), 32'd0);
        check("rstmid_count", 32'(count), 32'd0);
        check("rstmid_empty", 32'(empty), 32'd1);
        check("rstmid_overflow", 32'(overflow), 32'd0);
        check("rstmid_tx_byte", 32'(tx_byte), 32'h00);
        repeat (2) @(negedge clk);
        sent_q.delete();
        exp_q.delete();
        pulse_q.delete();
        push(8'h3C, 1'b1);
        drain("post_rst");
        check_stream("post_rst");

        check("tx_byte_stable", 32'(stab_err), 32'd0);
        check("pulse_after_idle", 32'(order_err), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/uart_tx_feeder.md
# uart_tx_feeder

Buffered byte source for the `uart` transmitter. It accepts bytes from fabric logic into a small synchronous FIFO and drains them one at a time into the UART's `transmit`/`tx_byte` inputs. It paces the drain against `is_transmitting` and honours the UART's recover rule: `transmit` must drop before the UART returns to idle. It sits between command/reply logic and `uart`, so producers never wait on the line.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries. Must be a power of two and ≥ 2.
- `ADDR_W`, log2(`DEPTH`): pointer width. Derived; not overridden.

Ports:
- `clk` in 1: system clock, same clock as `uart`.
- `rst` in 1: synchronous, active-high reset.
- `wr_en` in 1: push `wr_data` this cycle.
- `wr_data` in 8: byte to queue.
- `full` out 1: FIFO holds `DEPTH` entries.
- `empty` out 1: FIFO holds 0 entries.
- `count` out `ADDR_W`+1: current occupancy, 0..`DEPTH`.
- `overflow` out 1: sticky; set when a push is rejected. Cleared only by `rst`.
- `transmit` out 1: to `uart.transmit`. Registered.
- `tx_byte` out 8: to `uart.tx_byte`. Registered.
- `is_transmitting` in 1: from `uart.is_transmitting`.

## Operation
- FIFO:
  - Push when `wr_en && !full`.
  - `wr_en && full` drops the byte and sets `overflow`, even if a pop occurs in the same cycle.
  - Pop is internal, issued only by the FSM.
  - Simultaneous push and pop when not full: `count` unchanged, both pointers advance.
  - Pointers are `ADDR_W` bits and wrap modulo `DEPTH`. `count` is `ADDR_W`+1 bits and never wraps.
- FSM states: IDLE, ASSERT, WAIT_DONE.
  - IDLE: if `!empty && !is_transmitting`, then `tx_byte` <= head entry, pop, `transmit` <= 1, go to ASSERT.
  - ASSERT: hold `transmit`=1. When `is_transmitting`=1, `transmit` <= 0 and go to WAIT_DONE.
  - WAIT_DONE: `transmit`=0. When `is_transmitting`=0, go to IDLE.
- `tx_byte` changes only on the IDLE->ASSERT transition. It is stable through ASSERT and WAIT_DONE.
- Bytes leave in push order; none are lost or duplicated.
- Because `transmit` drops in ASSERT, the UART's recover stage exits immediately, so one byte is sent per `transmit` pulse.

## Timing
- Reset values: `transmit`=0, `tx_byte`=8'h00, `count`=0, `empty`=1, `full`=0, `overflow`=0, state=IDLE, pointers=0.
- `full`, `empty` and `count` reflect pushes and pops on the cycle after the edge that performed them.
- Push latency into an idle feeder with the UART idle: `wr_en` sampled at edge N, `count`=1 after N, `transmit`=1 after edge N+1.
- The UART raises `is_transmitting` one cycle after it samples `transmit`. A `transmit` pulse therefore lasts 2 cycles.
- Back-to-back bytes: the next `transmit` rises the cycle after `is_transmitting` is seen low in WAIT_DONE. The feeder adds 2 cycles of gap on top of the UART's own stop delay.
- Reset mid-operation:
  - FIFO is flushed and `transmit` drops on the next edge.
  - A byte already accepted by the UART completes only if the UART is not also reset. Normally both share `rst`.
- If `is_transmitting` is already high when entering IDLE with data queued, the feeder waits in IDLE with no pop.

## Structure
- `uart_pkg` holds:
  - the FSM state encoding (2-bit: IDLE=0, ASSERT=1, WAIT_DONE=2);
  - the `DEPTH` default;
  - the shared `log2` function.
- Sub-module `sync_fifo`:
  - parameterised width/depth, with push, pop, head data, `full`, `empty`, `count` and a registered memory;
  - reusable later for an RX-side buffer.
- The top level holds the FSM, the `tx_byte` register and the `overflow` flag.

## Test plan
- **Single byte:** after reset, push 8'hA5 with a behavioural UART model (`is_transmitting` high 1 cycle after `transmit`, low 20 cycles later) -> `transmit` high exactly 2 cycles with `tx_byte`=8'hA5; `count` returns to 0; `empty`=1.
- **Ordering:** push 8'h01..8'h05 on consecutive cycles -> five `transmit` pulses, `tx_byte` sequence 01,02,03,04,05, each pulse starting only after `is_transmitting` falls.
- **Full/overflow:** with the UART model held busy, push 17 bytes at `DEPTH`=16 -> `full`=1 and `count`=16 after the 16th push; 17th byte dropped; `overflow`=1 and remains 1 after draining; drained bytes are exactly the first 16.
- **Wrap-around:** push/drain 40 bytes 8'h00..8'h27 in bursts of 10 -> output matches the input sequence, pointers wrap twice, no loss.
- **Simultaneous push/pop:** with `count`=3, push 8'h7E on the cycle the FSM pops -> `count` stays 3, and 8'h7E is transmitted last.
- **Reset mid-frame:** assert `rst` for 1 cycle while in ASSERT with 4 bytes queued -> next cycle `transmit`=0, `count`=0, `empty`=1, `overflow`=0, `tx_byte`=8'h00; a subsequent push of 8'h3C transmits normally.
